lsu_mem_stage: RTL and testbench

- Memory-access stage directly downstream of instruction decode: consumes the decoded MREN/MWEN/UNSIGN micro-command fields, the ALU-computed address and the store data.
- Performs one byte/half/word load or store per request over a valid/ready memory port. Loads are sign- or zero-extended before write-back.
- Misaligned, illegal and timed-out accesses are reported through an error flag.

---
 rtl/lsu_mem_stage.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage. It takes one decoded byte/half/word access at a
// time, issues it on a valid/ready memory port, and returns the load data
// (sign- or zero-extended) or a store acknowledge to write-back.
// Misaligned accesses, illegal accesses (load and store in one request) and
// memory timeouts are returned with resp_err set.

// Store-lane helper for one byte lane of the 32-bit memory word.
// The parent passes in only the source bytes that this lane can select.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,      // 00 none, 01 byte, 10 half, 11 word
  input  logic [1:0] off,       // addr[1:0]
  input  logic [7:0] byte_src,  // wdata[7:0]
  input  logic [7:0] half_src,  // byte of wdata[15:0] that feeds this lane
  input  logic [7:0] word_src,  // wdata[8*LANE +: 8]
  output logic       strb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LIDX = 2'(LANE);

  // Pick the strobe and data byte from the access size and offset.
  // An aligned half has off[1] as its only offset bit, so off[1] selects
  // the upper or lower pair of lanes.
  always_comb begin
    strb  = 1'b0;
    wbyte = 8'h00;
    case (size)
      2'b01: begin
        strb  = (off == LIDX);
        wbyte = byte_src;
      end
      2'b10: begin
        strb  = (off[1] == LIDX[1]);
        wbyte = half_src;
      end
      2'b11: begin
        strb  = 1'b1;
        wbyte = word_src;
      end
      default: ;
    endcase
  end
endmodule

module lsu_mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mren,
  input  logic [1:0]        mwen,
  input  logic              unsign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);
  // Count value in the last WAIT cycle: the count reaches TIMEOUT on the edge
  // that leaves WAIT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [1:0]        r_mren;
  logic              r_unsign;
  logic [1:0]        r_off;

  logic [1:0]        size;
  logic              illegal, misalign, noop;
  logic [3:0]        lane_strb;
  logic [3:0][7:0]   lane_byte;
  logic [7:0]        rd_b;
  logic [15:0]       rd_h;
  logic [DATA_W-1:0] ld_data;

  // Classify the incoming request. When the request is legal, at most one of
  // mren and mwen is nonzero.
  assign size     = mren | mwen;
  assign illegal  = (mren != 2'b00) && (mwen != 2'b00);
  assign misalign = ((size == 2'b10) && addr[0]) ||
                    ((size == 2'b11) && (addr[1:0] != 2'b00));
  assign noop     = (size == 2'b00);

  // One lane per byte of the word. Loads give size 0, so their strobes and
  // write bytes are all zero.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    lsu_lane #(.LANE(l)) u_lane (
      .size     (mwen),
      .off      (addr[1:0]),
      .byte_src (wdata[7:0]),
      .half_src (wdata[8*(l%2) +: 8]),
      .word_src (wdata[8*l +: 8]),
      .strb     (lane_strb[l]),
      .wbyte    (lane_byte[l])
    );
  end

  // Take the addressed byte or half from the returned word and extend it.
  assign rd_b = mem_rdata[{r_off, 3'b000} +: 8];
  assign rd_h = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Build the load result. A store gives 0.
  always_comb begin
    ld_data = '0;
    case (r_mren)
      2'b01:   ld_data = {{24{~r_unsign & rd_b[7]}}, rd_b};
      2'b10:   ld_data = {{16{~r_unsign & rd_h[15]}}, rd_h};
      2'b11:   ld_data = mem_rdata;
      default: ld_data = '0;
    endcase
  end

  // Request FSM. All outputs are registered, so each one stays stable for as
  // long as its state is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      r_mren        <= 2'b00;
      r_unsign      <= 1'b0;
      r_off         <= 2'b00;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_mren    <= mren;
            r_unsign  <= unsign;
            r_off     <= addr[1:0];
            req_ready <= 1'b0;
            resp_data <= '0;
            if (illegal || misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (noop) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= (mwen != 2'b00);
              mem_addr      <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata     <= lane_byte;
              mem_wstrb     <= lane_strb;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            cnt           <= 8'd0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A response in the timeout cycle still counts as a success.
          if (mem_resp_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ld_data;
          end else if (cnt == TO_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage. It applies a table of access vectors and plays the
// memory and write-back sides cycle by cycle. A queue holds the expected
// response for each request, and each response is checked against it when
// resp_valid appears. Hand-written sequences cover stalls, timeout and reset.
module tb_lsu_mem_stage;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  mren, mwen;
  logic        unsign;
  logic [31:0] addr, wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mren(mren), .mwen(mwen), .unsign(unsign), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mren, mwen;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        mem;     // a memory transaction is expected
    logic        we;
    logic [31:0] maddr, mwdata;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  vec_t  tbl[16];
  int    total = 0;
  int    bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic [1:0] mr, logic [1:0] mw, logic u,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              logic m, logic we, logic [31:0] ma, logic [31:0] mwd,
                              logic [3:0] st, logic [31:0] d, logic e);
    vec_t v;
    v.mren = mr; v.mwen = mw; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.mem = m; v.we = we; v.maddr = ma; v.mwdata = mwd; v.wstrb = st;
    v.data = d; v.err = e;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},     32'(req_ready),     32'd1);
    chk({tag, "_resp_valid"},    32'(resp_valid),    32'd0);
    chk({tag, "_resp_err"},      32'(resp_err),      32'd0);
    chk({tag, "_resp_data"},     resp_data,          32'd0);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_we"},        32'(mem_we),        32'd0);
    chk({tag, "_mem_addr"},      mem_addr,           32'd0);
    chk({tag, "_mem_wdata"},     mem_wdata,          32'd0);
    chk({tag, "_mem_wstrb"},     32'(mem_wstrb),     32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Run one request. The memory raises ready after rdy_dly cycles of
  // mem_req_valid and responds in WAIT cycle rsp_dly (0 = first WAIT cycle),
  // or never when no_resp is set. Write-back holds resp_ready low for rr_dly
  // cycles. exp_lat counts cycles from the accept edge to the first
  // resp_valid.
  task automatic run(input vec_t v, input int rdy_dly, input int rsp_dly,
                     input int rr_dly, input bit no_resp, input int exp_lat);
    int k, nreq, wcnt, nresp;
    bit in_wait, hs, done, first_rv;
    resp_t r;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; mren = v.mren; mwen = v.mwen; unsign = v.uns;
    addr = v.addr; wdata = v.wdata;
    r.data = v.data; r.err = v.err;
    exp_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0; mren = 2'b00; mwen = 2'b00; unsign = 1'b0;
    addr = 32'h0; wdata = $urandom;
    k = 1; nreq = 0; wcnt = 0; nresp = 0;
    in_wait = 0; done = 0; first_rv = 1;
    while (!done && k < 100) begin
      hs = 0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
      mem_rdata = $urandom;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (!v.mem) chk("no_mem_req", 32'(mem_req_valid), 32'd0);
      if (in_wait) begin
        chk("mem_req_drop", 32'(mem_req_valid), 32'd0);
        if (!resp_valid) begin
          if (!no_resp && wcnt == rsp_dly) begin
            mem_resp_valid = 1'b1;
            mem_rdata = v.rdata;
          end
          wcnt++;
        end
      end else if (mem_req_valid) begin
        chk("mem_addr",  mem_addr,        v.maddr);
        chk("mem_we",    32'(mem_we),     32'(v.we));
        chk("mem_wstrb", 32'(mem_wstrb),  32'(v.wstrb));
        if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
        if (nreq >= rdy_dly) begin
          mem_req_ready = 1'b1;
          hs = 1;
        end
        nreq++;
      end
      if (resp_valid) begin
        if (first_rv) begin
          first_rv = 0;
          chk("latency", 32'(k), 32'(exp_lat));
        end
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          r = exp_q[0];
          chk("resp_data", resp_data,      r.data);
          chk("resp_err",  32'(resp_err),  32'(r.err));
        end
        if (nresp >= rr_dly) begin
          resp_ready = 1'b1;
          done = 1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        nresp++;
      end
      @(posedge clk); #1;
      if (hs) in_wait = 1;
      k++;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_budget act=no_resp_handshake exp=handshake k=%0d", k);
      exp_q.delete();
      do_reset();
    end else begin
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("resp_valid_after", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    //           mren  mwen  u  addr          wdata         rdata        mem we maddr         mwdata        wstrb    data          err
    tbl[0]  = mk(2'd0, 2'd1, 0, 32'h8000_0003, 32'h1234_56AB, 32'h0,        1, 1, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 32'h0,         0);
    tbl[1]  = mk(2'd2, 2'd0, 0, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_8001, 0);
    tbl[2]  = mk(2'd2, 2'd0, 1, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_8001, 0);
    tbl[3]  = mk(2'd3, 2'd0, 0, 32'h0000_0101, 32'h0,         32'h0,        0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1);
    tbl[4]  = mk(2'd1, 2'd0, 0, 32'h0000_0201, 32'h0,         32'h1122_8344, 1, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_FF83, 0);
    tbl[5]  = mk(2'd1, 2'd0, 1, 32'h0000_0203, 32'h0,         32'hF0AA_0000, 1, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_00F0, 0);
    tbl[6]  = mk(2'd2, 2'd0, 1, 32'h0000_0300, 32'h0,         32'h1234_FEDC, 1, 0, 32'h0000_0300, 32'h0,        4'b0000, 32'h0000_FEDC, 0);
    tbl[7]  = mk(2'd3, 2'd0, 1, 32'h0000_0404, 32'h0,         32'h8765_4321, 1, 0, 32'h0000_0404, 32'h0,        4'b0000, 32'h8765_4321, 0);
    tbl[8]  = mk(2'd0, 2'd2, 0, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0,        1, 1, 32'h0000_0010, 32'hBEEF_BEEF, 4'b1100, 32'h0,         0);
    tbl[9]  = mk(2'd0, 2'd2, 0, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1);
    tbl[10] = mk(2'd0, 2'd3, 0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        1, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'h0,         0);
    tbl[11] = mk(2'd0, 2'd3, 0, 32'h0000_0022, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1);
    tbl[12] = mk(2'd1, 2'd1, 0, 32'h0000_0040, 32'h0000_0011, 32'h0,        0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         1);
    tbl[13] = mk(2'd0, 2'd0, 0, 32'h0000_0044, 32'h0000_0011, 32'h0,        0, 0, 32'h0,         32'h0,        4'b0000, 32'h0,         0);
    tbl[14] = mk(2'd0, 2'd1, 0, 32'h0000_0001, 32'h0000_0055, 32'h0,        1, 1, 32'h0000_0000, 32'h5555_5555, 4'b0010, 32'h0,         0);
    tbl[15] = mk(2'd1, 2'd0, 0, 32'h0000_0002, 32'h0,         32'h007F_0000, 1, 0, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_007F, 0);

    rst_n = 1'b0; req_valid = 1'b0; mren = 2'b00; mwen = 2'b00; unsign = 1'b0;
    addr = 32'h0; wdata = 32'h0; resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    @(posedge clk); #1;
    chk_reset_vals("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table pass with a zero-wait memory and write-back.
    for (int i = 0; i < 16; i++)
      run(tbl[i], 0, 0, 0, 0, tbl[i].mem ? 3 : 1);

    // Stalled memory request and stalled write-back.
    run(tbl[0], 5, 2, 3, 0, 3 + 5 + 2);
    run(tbl[1], 5, 1, 3, 0, 3 + 5 + 1);

    // Timeout with no memory response.
    v = tbl[7]; v.data = 32'h0; v.err = 1'b1;
    run(v, 0, 0, 0, 1, 2 + TO);
    // Response in the last WAIT cycle takes priority over the timeout.
    run(tbl[7], 0, TO - 1, 0, 0, 2 + TO);
    run(tbl[4], 2, TO - 1, 1, 0, 2 + 2 + TO);

    // Reset during WAIT, then a stray memory response while IDLE.
    req_valid = 1'b1; mren = tbl[7].mren; mwen = 2'b00; addr = tbl[7].addr;
    @(posedge clk); #1;
    req_valid = 1'b0; mren = 2'b00; addr = 32'h0;
    chk("rst_seq_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_0001;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_resp_valid", 32'(resp_valid), 32'd0);
      chk("stray_req_ready",  32'(req_ready),  32'd1);
      chk("stray_mem_req",    32'(mem_req_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Normal operation after reset.
    run(tbl[2], 0, 0, 0, 0, 3);
    run(tbl[10], 1, 0, 0, 0, 4);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
